// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Owner encoding tags which port the in-flight read belongs to.
package mem_arb_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 32;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    function automatic owner_t port_owner(input logic is_b);
        return is_b ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb2_rr.sv
// Two-way arbiter: round-robin or fixed B-priority on a tie.
// The last-granted pointer only moves when someone is granted.
module arb2_rr
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    logic last_reg;

    // Grants are forced low for as long as reset is held.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_en && last_reg == PORT_B) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= PORT_B;
        end else if (gnt[0]) begin
            last_reg <= PORT_A;
        end else if (gnt[1]) begin
            last_reg <= PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction fetch (A) and load/store (B) onto one synchronous
// memory port and steers the registered read data back to its owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int RR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_datain,
    input  logic [DW-1:0] mem_dataout
);

    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata [2];
    owner_t        owner_reg;
    owner_t        owner_next;

    arb2_rr u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({b_req, a_req}),
        .rr_en (RR != 0),
        .gnt   (gnt)
    );

    assign a_gnt       = gnt[0];
    assign b_gnt       = gnt[1];
    assign mem_we      = gnt[1] & b_we;
    assign mem_address = gnt[1] ? b_addr : a_addr;
    assign mem_datain  = b_wdata;

    // Fetch port is read-only, so any A grant starts a read.
    always_comb begin
        owner_next = OWN_NONE;
        if (gnt[0]) begin
            owner_next = OWN_A;
        end else if (gnt[1] && !b_we) begin
            owner_next = OWN_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= OWN_NONE;
        end else begin
            owner_reg <= owner_next;
        end
    end

    // Per-port return path: live data while valid, last returned word otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            logic [DW-1:0] hold_reg;

            assign rvalid[gi] = (owner_reg == port_owner(gi == 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                end else if (rvalid[gi]) begin
                    hold_reg <= mem_dataout;
                end
            end

            assign rdata[gi] = rvalid[gi] ? mem_dataout : hold_reg;
        end
    endgenerate

    assign a_rvalid = rvalid[0];
    assign b_rvalid = rvalid[1];
    assign a_rdata  = rdata[0];
    assign b_rdata  = rdata[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin instance with a memory model and
// scoreboard, plus a fixed-priority instance for the B-wins case.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    // Round-robin instance
    logic          a_req = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we;
    logic [DW-1:0] a_rdata, b_rdata, mem_datain;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_dout = '0;
    logic [DW-1:0] mem_arr [4096];

    // Fixed-priority instance
    logic          z_a_req = 1'b0, z_b_req = 1'b0;
    logic          z_a_gnt, z_b_gnt, z_a_rvalid, z_b_rvalid, z_mem_we;
    logic [DW-1:0] z_a_rdata, z_b_rdata, z_mem_datain;
    logic [AW-1:0] z_mem_address;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] shadow [4096];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];
    logic [DW-1:0] a_last = '0;
    logic [DW-1:0] b_last = '0;

    typedef struct {
        logic          ar;
        logic [AW-1:0] aa;
        logic          br;
        logic          bw;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic          ea;
        logic          eb;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_address] <= mem_datain;
        else        mem_dout <= mem_arr[mem_address];
    end

    mem_arbiter #(.AW(AW), .DW(DW), .RR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_address(mem_address), .mem_datain(mem_datain),
        .mem_dataout(mem_dout)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_req(z_a_req), .a_addr(12'h100), .a_gnt(z_a_gnt), .a_rvalid(z_a_rvalid), .a_rdata(z_a_rdata),
        .b_req(z_b_req), .b_we(1'b0), .b_addr(12'h200), .b_wdata(32'h0),
        .b_gnt(z_b_gnt), .b_rvalid(z_b_rvalid), .b_rdata(z_b_rdata),
        .mem_we(z_mem_we), .mem_address(z_mem_address), .mem_datain(z_mem_datain),
        .mem_dataout(32'h0)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Compare the return path of both ports against the scoreboard.
    task automatic check_return(input string nm);
        logic [DW-1:0] e;
        chk({nm, " a_rvalid"}, {31'b0, a_rvalid}, {31'b0, qa.size() > 0});
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk({nm, " a_rdata"}, a_rdata, e);
            a_last = e;
        end else begin
            chk({nm, " a_rdata hold"}, a_rdata, a_last);
        end
        chk({nm, " b_rvalid"}, {31'b0, b_rvalid}, {31'b0, qb.size() > 0});
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk({nm, " b_rdata"}, b_rdata, e);
            b_last = e;
        end else begin
            chk({nm, " b_rdata hold"}, b_rdata, b_last);
        end
    endtask

    // Called at posedge+1; drives one cycle, checks at the negedge.
    task automatic do_cycle(input logic ar, input logic [AW-1:0] aa,
                            input logic br, input logic bw, input logic [AW-1:0] ba,
                            input logic [DW-1:0] bd, input logic ea, input logic eb,
                            input string nm);
        logic [AW-1:0] exp_addr;
        a_req = ar; a_addr = aa; b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #4;
        exp_addr = eb ? ba : aa;
        chk({nm, " a_gnt"}, {31'b0, a_gnt}, {31'b0, ea});
        chk({nm, " b_gnt"}, {31'b0, b_gnt}, {31'b0, eb});
        chk({nm, " mem_we"}, {31'b0, mem_we}, {31'b0, eb & bw});
        chk({nm, " mem_address"}, {20'b0, mem_address}, {20'b0, exp_addr});
        if (eb && bw) chk({nm, " mem_datain"}, mem_datain, bd);
        check_return(nm);
        $display("cycle %s: a_gnt=%0b b_gnt=%0b a_rdata=%h b_rdata=%h", nm, a_gnt, b_gnt, a_rdata, b_rdata);
        if (ea) qa.push_back(shadow[aa]);
        if (eb) begin
            if (bw) shadow[ba] = bd;
            else    qb.push_back(shadow[ba]);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input string nm);
        do_cycle(1'b0, 12'h3FF, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, nm);
    endtask

    initial begin
        // Round-robin tie from a B-last state, then single-requester cases.
        vecs[0] = '{1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 32'h0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 32'h0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 32'h0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 32'h0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 32'h0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 12'h123, 1'b0, 1'b0, 12'h456, 32'h0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 12'h020, 1'b0, 1'b0, 12'h456, 32'h0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 12'h123, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b1};

        // Reset state, with requests asserted so the gating is visible.
        a_req = 1'b1; b_req = 1'b1; b_we = 1'b1;
        z_a_req = 1'b1; z_b_req = 1'b1;
        @(negedge clk);
        chk("reset a_gnt", {31'b0, a_gnt}, 32'd0);
        chk("reset b_gnt", {31'b0, b_gnt}, 32'd0);
        chk("reset mem_we", {31'b0, mem_we}, 32'd0);
        chk("reset z_b_gnt", {31'b0, z_b_gnt}, 32'd0);
        check_return("reset");
        #2;
        a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed priority: B wins every tie, A granted as soon as B drops.
        for (int i = 0; i < 4; i++) begin
            #4;
            chk("fp b_gnt", {31'b0, z_b_gnt}, 32'd1);
            chk("fp a_gnt", {31'b0, z_a_gnt}, 32'd0);
            $display("fp cycle %0d: a_gnt=%0b b_gnt=%0b", i, z_a_gnt, z_b_gnt);
            @(posedge clk); #1;
        end
        z_b_req = 1'b0;
        #1;
        chk("fp a_gnt after b drop", {31'b0, z_a_gnt}, 32'd1);
        @(posedge clk); #1;
        z_a_req = 1'b0;

        // Preload through the B write path.
        do_cycle(1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b1, "preload 010");
        do_cycle(1'b0, 12'h000, 1'b1, 1'b1, 12'h020, 32'h12345678, 1'b0, 1'b1, "preload 020");
        idle("idle");

        // Single fetch read, then data held for several cycles.
        do_cycle(1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, "a read 010");
        for (int i = 0; i < 5; i++) idle("a hold");

        // Leave the pointer on B, then run the vector table.
        do_cycle(1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 32'h0, 1'b0, 1'b1, "b read 020");
        for (int i = 0; i < 9; i++) begin
            do_cycle(vecs[i].ar, vecs[i].aa, vecs[i].br, vecs[i].bw, vecs[i].ba,
                     vecs[i].bd, vecs[i].ea, vecs[i].eb, $sformatf("vec%0d", i));
        end
        idle("drain");

        // Write then read of the same address.
        do_cycle(1'b0, 12'h000, 1'b1, 1'b1, 12'h055, 32'hCAFEF00D, 1'b0, 1'b1, "b write 055");
        do_cycle(1'b0, 12'h000, 1'b1, 1'b0, 12'h055, 32'h0, 1'b0, 1'b1, "b read 055");
        idle("raw return");

        // Read then write of the same address.
        do_cycle(1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b1, "b read 010");
        do_cycle(1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 32'h00000001, 1'b0, 1'b1, "b write 010");
        do_cycle(1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, "a reread 010");
        idle("war return");

        // Reset in the middle of an accepted fetch read.
        a_req = 1'b1; a_addr = 12'h020; b_req = 1'b0; b_we = 1'b0;
        #2;
        chk("pre-reset a_gnt", {31'b0, a_gnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("in-reset a_gnt", {31'b0, a_gnt}, 32'd0);
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h020; b_wdata = 32'hBAD0BAD0;
        #1;
        chk("in-reset b_gnt", {31'b0, b_gnt}, 32'd0);
        chk("in-reset mem_we", {31'b0, mem_we}, 32'd0);
        $display("reset pulse: a_gnt=%0b b_gnt=%0b mem_we=%0b", a_gnt, b_gnt, mem_we);
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        #2;
        rst_n = 1'b1;
        qa.delete(); qb.delete();
        a_last = '0; b_last = '0;
        @(negedge clk);
        check_return("post-reset");
        $display("post-reset: a_rvalid=%0b a_rdata=%h b_rdata=%h", a_rvalid, a_rdata, b_rdata);
        @(posedge clk); #1;

        // First tie after reset goes to A; the write during reset never landed.
        do_cycle(1'b1, 12'h020, 1'b1, 1'b0, 12'h055, 32'h0, 1'b1, 1'b0, "post-reset tie");
        do_cycle(1'b0, 12'h000, 1'b1, 1'b0, 12'h055, 32'h0, 1'b0, 1'b1, "post-reset b");
        idle("final drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
